// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory handshake plus control-side signals of the fetch stage.
interface fetch_stage_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              imemReq;
    logic [ADDR_W-1:0] imemAddr;
    logic [15:0]       imemRdata;
    logic              imemValid;
    logic [1:0]        pcSource;
    logic              halt;
    logic              stall;
    logic [ADDR_W-1:0] regTarget;
    logic [15:0]       instr;
    logic [3:0]        opCode;
    logic [3:0]        functionCode;
    logic [ADDR_W-1:0] pcPlus2;
    logic              instrValid;
    logic              halted;
    logic [CNT_W-1:0]  retireCount;

    modport master (
        output imemReq, imemAddr, instr, opCode, functionCode, pcPlus2, instrValid, halted, retireCount,
        input  imemRdata, imemValid, pcSource, halt, stall, regTarget
    );
    modport slave (
        input  imemReq, imemAddr, instr, opCode, functionCode, pcPlus2, instrValid, halted, retireCount,
        output imemRdata, imemValid, pcSource, halt, stall, regTarget
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, fetches from variable-latency imem into an IF/ID register,
// selects the next PC from control and stops permanently on halt.
module fetch_stage #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                CNT_W    = 16
) (
    input logic           clk,
    input logic           rst_n,
    fetch_stage_if.master bus
);
    typedef enum logic [1:0] {INIT, FETCH, DECODE, HALTED} state_t;
    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_pc_plus2;
    logic [15:0]       r_instr;
    logic              r_valid;
    logic              r_halted;
    logic              r_req;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] w_branch;
    logic [ADDR_W-1:0] w_jump;
    logic [ADDR_W-1:0] w_reg;
    logic [ADDR_W-1:0] w_next_pc;
    // Branch offset is a signed halfword count relative to pc+2.
    assign w_branch  = r_pc_plus2 + {{(ADDR_W-9){r_instr[7]}}, r_instr[7:0], 1'b0};
    assign w_jump    = {r_pc[ADDR_W-1:13], r_instr[11:0], 1'b0};
    assign w_reg     = bus.regTarget & ~ADDR_W'(1);
    assign w_next_pc = bus.pcSource == 2'b00 ? r_pc_plus2 :
                       bus.pcSource == 2'b01 ? w_branch :
                       bus.pcSource == 2'b10 ? w_jump : w_reg;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= INIT;
            r_pc       <= RESET_PC;
            r_pc_plus2 <= RESET_PC + ADDR_W'(2);
            r_instr    <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
            r_req      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                INIT: begin
                    r_state <= FETCH;
                    r_req   <= 1'b1;
                end
                FETCH: if (bus.imemValid) begin
                    r_instr <= bus.imemRdata;
                    r_valid <= 1'b1;
                    r_req   <= 1'b0;
                    r_state <= DECODE;
                end
                DECODE: if (!bus.stall) begin
                    r_valid <= 1'b0;
                    r_cnt   <= r_cnt + 1'b1;
                    if (bus.halt) begin
                        r_halted <= 1'b1;
                        r_state  <= HALTED;
                    end else begin
                        r_pc       <= w_next_pc;
                        r_pc_plus2 <= w_next_pc + ADDR_W'(2);
                        r_req      <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
                default: ;
            endcase
        end
    end
    assign bus.imemReq      = r_req;
    assign bus.imemAddr     = r_pc;
    assign bus.instr        = r_instr;
    assign bus.opCode       = r_instr[15:12];
    assign bus.functionCode = r_instr[3:0];
    assign bus.pcPlus2      = r_pc_plus2;
    assign bus.instrValid   = r_valid;
    assign bus.halted       = r_halted;
    assign bus.retireCount  = r_cnt;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed fetch/decode vectors; expected fetch addresses and IF/ID
// contents go into queues that a negedge monitor pops on each new request or new instruction.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    int exp_cnt = 0;
    logic [15:0] q_addr[$];
    logic [39:0] q_dec[$];
    logic prev_req = 1'b0;
    logic prev_valid = 1'b0;

    fetch_stage_if #(.ADDR_W(16), .CNT_W(4)) bus();
    fetch_stage #(.ADDR_W(16), .RESET_PC(16'h0000), .CNT_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.imemReq === 1'b1 && prev_req !== 1'b1) begin
            if (q_addr.size() == 0) chk("addr_unexpected", {24'd0, bus.imemAddr}, 40'hFFFFFFFFFF);
            else chk("fetch_addr", {24'd0, bus.imemAddr}, {24'd0, q_addr.pop_front()});
        end
        if (rst_n && bus.instrValid === 1'b1 && prev_valid !== 1'b1) begin
            if (q_dec.size() == 0) chk("dec_unexpected", {24'd0, bus.instr}, 40'hFFFFFFFFFF);
            else chk("decode", {bus.instr, bus.opCode, bus.functionCode, bus.pcPlus2}, q_dec.pop_front());
        end
        prev_req   <= bus.imemReq;
        prev_valid <= bus.instrValid;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] addr, input logic [15:0] data, input logic [15:0] pc2, input int lat);
        int n = 0;
        q_dec.push_back({data, data[15:12], data[3:0], pc2});
        while (bus.imemReq !== 1'b1 && n < 50) begin
            cyc();
            n++;
        end
        chk("req_wait", {39'd0, bus.imemReq}, 40'd1);
        repeat (lat - 1) cyc();
        chk("req_hold", {22'd0, bus.imemReq, bus.instrValid, bus.imemAddr}, {22'd0, 1'b1, 1'b0, addr});
        bus.imemValid = 1'b1;
        bus.imemRdata = data;
        cyc();
        bus.imemValid = 1'b0;
        bus.imemRdata = 16'hDEAD;
    endtask

    task automatic step(input logic [15:0] addr, input logic [15:0] data, input logic [15:0] pc2,
                        input int lat, input logic [1:0] src, input logic [15:0] tgt, input logic [15:0] nxt);
        fetch(addr, data, pc2, lat);
        q_addr.push_back(nxt);
        bus.pcSource  = src;
        bus.regTarget = tgt;
        cyc();
        exp_cnt++;
        chk("retire", {36'd0, bus.retireCount}, 40'(exp_cnt % 16));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.imemValid = 1'b0;
        bus.imemRdata = 16'h0000;
        bus.pcSource  = 2'b00;
        bus.halt      = 1'b0;
        bus.stall     = 1'b0;
        bus.regTarget = 16'h0000;
        repeat (2) cyc();
        chk("rst_req", {39'd0, bus.imemReq}, 40'd0);
        chk("rst_pc", {24'd0, bus.imemAddr}, 40'h0000);
        chk("rst_instr", {24'd0, bus.instr}, 40'h0000);
        chk("rst_flags", {37'd0, bus.instrValid, bus.halted, 1'b0}, 40'd0);
        chk("rst_cnt", {36'd0, bus.retireCount}, 40'd0);
        q_addr.push_back(16'h0000);
        rst_n = 1'b1;
        step(16'h0000, 16'h0001, 16'h0002, 1, 2'b00, 16'h0000, 16'h0002);
        step(16'h0002, 16'hF0A5, 16'h0004, 2, 2'b11, 16'h0011, 16'h0010);
        step(16'h0010, 16'hA010, 16'h0012, 5, 2'b10, 16'h0000, 16'h0020);
        step(16'h0020, 16'h40FC, 16'h0022, 1, 2'b01, 16'h0000, 16'h001A);
        step(16'h001A, 16'h1234, 16'h001C, 3, 2'b11, 16'h0021, 16'h0020);
        step(16'h0020, 16'hB123, 16'h0022, 1, 2'b10, 16'h0000, 16'h0246);
        step(16'h0246, 16'h7777, 16'h0248, 2, 2'b11, 16'h1235, 16'h1234);
        step(16'h1234, 16'h3C3C, 16'h1236, 1, 2'b11, 16'hFFFF, 16'hFFFE);
        step(16'hFFFE, 16'h5005, 16'h0000, 1, 2'b00, 16'h0000, 16'h0000);
        for (int i = 0; i < 7; i++)
            step(16'(2 * i), 16'(16'h0100 + i), 16'(2 * i + 2), 1 + i % 3, 2'b00, 16'h0000, 16'(2 * i + 2));
        chk("cnt_wrap", {36'd0, bus.retireCount}, 40'd0);
        step(16'h000E, 16'h6E6E, 16'h0010, 1, 2'b11, 16'h0040, 16'h0040);
        repeat (2) cyc();
        chk("mid_fetch", {23'd0, bus.imemReq, bus.imemAddr}, {23'd0, 1'b1, 16'h0040});
        rst_n = 1'b0;
        cyc();
        chk("rst2_state", {21'd0, bus.imemReq, bus.instrValid, bus.halted, bus.imemAddr}, {21'd0, 3'b000, 16'h0000});
        chk("rst2_cnt", {36'd0, bus.retireCount}, 40'd0);
        rst_n = 1'b1;
        q_addr.push_back(16'h0000);
        bus.imemValid = 1'b1;
        bus.imemRdata = 16'hDEAD;
        cyc();
        bus.imemValid = 1'b0;
        chk("init_ignore", {38'd0, bus.imemReq, bus.instrValid}, {38'd0, 2'b10});
        chk("init_instr", {24'd0, bus.instr}, 40'h0000);
        exp_cnt = 0;
        fetch(16'h0000, 16'h9ABC, 16'h0002, 2);
        bus.stall = 1'b1;
        bus.halt = 1'b1;
        bus.pcSource = 2'b01;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_hold", {2'd0, bus.instrValid, bus.halted, bus.imemReq, bus.imemAddr, bus.instr, 3'd0},
                {2'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9ABC, 3'd0});
        end
        bus.stall = 1'b0;
        cyc();
        chk("halt_enter", {38'd0, bus.halted, bus.instrValid}, {38'd0, 2'b10});
        chk("halt_retire", {36'd0, bus.retireCount}, 40'd1);
        bus.halt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.imemValid = ~bus.imemValid;
            cyc();
            chk("halted_idle", {21'd0, bus.imemReq, bus.instrValid, bus.halted, bus.imemAddr},
                {21'd0, 3'b001, 16'h0000});
        end
        bus.imemValid = 1'b0;
        chk("queues_drained", {8'd0, 16'(q_addr.size()), 16'(q_dec.size())}, 40'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
